// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: folds a stream of 19-bit operand pairs into one redundant
// (carry, sum) result using a single time-multiplexed 4:2 compressor.
// Optional macro CSA_ACCUM_RESOLVE_EN adds a RESOLVE state that registers the
// carry-propagate sum into out_sum; without it out_sum is tied to zero.
//
// state   | meaning
// IDLE    | waiting for start, accumulator idle
// ACCUM   | accepting operand beats, one per cycle
// RESOLVE | one cycle carry-propagate of the result (macro builds only)
// DONE    | result presented, waiting for out_ready

// 4:2 carry-save compressor built from two full-adder layers.
// Carry outputs are pre-shifted to their true weight; bit 18 carries fall off.
module add_16_4 (
    input  logic [18:0] in0,
    input  logic [18:0] in1,
    input  logic [18:0] in2,
    input  logic [18:0] in3,
    output logic [18:0] c,
    output logic [18:0] s
);
    logic [18:0] s1;
    logic [17:0] c1;
    logic [18:0] c1_w;
    logic [17:0] c2;

    assign s1   = in0 ^ in1 ^ in2;
    assign c1   = (in0[17:0] & in1[17:0]) | (in0[17:0] & in2[17:0]) | (in1[17:0] & in2[17:0]);
    assign c1_w = {c1, 1'b0};
    assign s    = s1 ^ c1_w ^ in3;
    assign c2   = (s1[17:0] & c1_w[17:0]) | (s1[17:0] & in3[17:0]) | (c1_w[17:0] & in3[17:0]);
    assign c    = {c2, 1'b0};
endmodule

module csa_accum_ctrl #(
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_beats,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0][18:0]      in_a,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [18:0]           out_c,
    output logic [18:0]           out_s,
    output logic [18:0]           out_sum,
    output logic                  busy
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

`ifdef CSA_ACCUM_RESOLVE_EN
    localparam logic [1:0] FINISH = RESOLVE;
`else
    localparam logic [1:0] FINISH = DONE;
`endif

    localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] beats_eff;
    logic [18:0]      acc_c;
    logic [18:0]      acc_s;
    logic [18:0]      cmp_c;
    logic [18:0]      cmp_s;

    assign beats_eff = (num_beats > MAX_B) ? MAX_B : num_beats;

    add_16_4 u_cmp (
        .in0 (acc_s),
        .in1 (acc_c),
        .in2 (in_a[0]),
        .in3 (in_a[1]),
        .c   (cmp_c),
        .s   (cmp_s)
    );

    // Handshake flags come straight from the state register, so no input reaches in_ready.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Sequencer, accumulator and result registers; result only loads on the final beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            acc_c <= '0;
            acc_s <= '0;
            out_c <= '0;
            out_s <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_c <= '0;
                        acc_s <= '0;
                        cnt   <= beats_eff;
                        if (beats_eff == '0) begin
                            out_c <= '0;
                            out_s <= '0;
                            state <= FINISH;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_c <= cmp_c;
                        acc_s <= cmp_s;
                        cnt   <= cnt - ONE;
                        if (cnt == ONE) begin
                            out_c <= cmp_c;
                            out_s <= cmp_s;
                            state <= FINISH;
                        end
                    end
                end
                RESOLVE: state <= DONE;
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
            endcase
        end
    end

`ifdef CSA_ACCUM_RESOLVE_EN
    logic [18:0] sum_q;

    // Carry-propagate the held redundant pair once, during RESOLVE.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else if (state == RESOLVE) begin
            sum_q <= out_c + out_s;
        end
    end

    assign out_sum = sum_q;
`else
    assign out_sum = '0;
`endif
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Self-checking bench for csa_accum_ctrl; expectations follow the macro setting.
module tb_csa_accum_ctrl;
    localparam int MAX_BEATS = 16;
    localparam int CNT_W     = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_beats;
    logic             in_valid;
    logic             in_ready;
    logic [1:0][18:0] in_a;
    logic             out_valid;
    logic             out_ready;
    logic [18:0]      out_c;
    logic [18:0]      out_s;
    logic [18:0]      out_sum;
    logic             busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [18:0] ops [64];

    always #5 clk = ~clk;

    csa_accum_ctrl #(.MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_beats (num_beats),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_s     (out_s),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain sum of every operand the job consumes, modulo 2^19.
    function automatic logic [18:0] model_sum(input int beats);
        longint total = 0;
        for (int k = 0; k < 2 * beats; k++) total += longint'(ops[k]);
        return 19'(total);
    endfunction

    // Runs one job starting at a negedge; ends at the negedge after the out handshake.
    task automatic run_job(input int nb, input bit gaps, input int bp);
        int          eff;
        int          idx;
        int          cyc;
        bit          acc_ok;
        logic [18:0] exp_sum;
        logic [18:0] hold_c;
        logic [18:0] hold_s;
        eff     = (nb > MAX_BEATS) ? MAX_BEATS : nb;
        exp_sum = model_sum(eff);

        chk("idle_in_ready", in_ready, 0);
        chk("idle_out_valid", out_valid, 0);
        start     = 1'b1;
        num_beats = CNT_W'(nb);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);

        if (eff > 0) begin
            chk("in_ready_t1", in_ready, 1);
            idx = 0;
            cyc = 0;
            while (idx < eff && cyc < 400) begin
                in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_a[0]  = ops[2*idx];
                in_a[1]  = ops[2*idx+1];
                acc_ok   = in_valid && in_ready;
                if (in_valid && !in_ready) chk("in_ready_accum", in_ready, 1);
                @(posedge clk);
                @(negedge clk);
                cyc++;
                if (acc_ok) idx++;
            end
            in_valid = 1'b0;
            chk("beats_accepted", idx, eff);
            if (!gaps) chk("throughput", cyc, eff);
        end else begin
            chk("zero_no_in_ready", in_ready, 0);
        end

`ifdef CSA_ACCUM_RESOLVE_EN
        chk("resolve_gap", out_valid, 0);
        chk("resolve_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        chk("out_sum", out_sum, exp_sum);
`else
        chk("out_sum_tied", out_sum, 0);
`endif
        chk("out_valid_lat", out_valid, 1);
        chk("done_in_ready", in_ready, 0);
        chk("redundant_sum", 19'(out_c + out_s), exp_sum);
        if (eff == 0) begin
            chk("zero_out_c", out_c, 0);
            chk("zero_out_s", out_s, 0);
        end

        hold_c    = out_c;
        hold_s    = out_s;
        out_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            start     = (i == 1);
            num_beats = CNT_W'(3);
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_c_stable", out_c, hold_c);
            chk("bp_out_s_stable", out_s, hold_s);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("handshake_out_valid", out_valid, 0);
        chk("handshake_busy", busy, 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        num_beats = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_c", out_c, 0);
        chk("rst_out_s", out_s, 0);
        chk("rst_out_sum", out_sum, 0);
        reset = 1'b0;
        @(negedge clk);

        // single beat {2,1}
        ops[0] = 19'd1;
        ops[1] = 19'd2;
        run_job(1, 1'b0, 0);

        // wrap-around with all-ones operands
        for (int k = 0; k < 8; k++) ops[k] = 19'h7FFFF;
        run_job(4, 1'b0, 0);

        // operands 1..32 with input gaps and backpressure
        for (int k = 0; k < 32; k++) ops[k] = 19'(k + 1);
        run_job(16, 1'b1, 5);

        // zero-beat job
        run_job(0, 1'b0, 2);

        // reset after 3 of 8 beats
        for (int k = 0; k < 16; k++) ops[k] = 19'($urandom);
        start     = 1'b1;
        num_beats = CNT_W'(8);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_a[0]  = ops[2*b];
            in_a[1]  = ops[2*b+1];
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_c", out_c, 0);
        chk("midrst_out_s", out_s, 0);
        chk("midrst_out_sum", out_sum, 0);
        for (int k = 0; k < 4; k++) ops[k] = 19'd5;
        run_job(2, 1'b0, 0);

        // back-to-back random jobs, including clamped lengths
        for (int j = 0; j < 20; j++) begin
            for (int k = 0; k < 64; k++) ops[k] = 19'($urandom);
            run_job($urandom_range(0, 20), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
